// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder: multi-cycle data-memory responder for the core's load/store
// port. One request at a time: IDLE accepts, WAIT inserts WAIT_CYCLES wait
// states, RESP holds the registered response until the core consumes it.
// Storage is DEPTH_WORDS x 32 bits, not reset.
//
// Optional feature macro: DMEM_BYTE_EN
//   defined   -> req_be selects which bytes a store writes
//   undefined -> every store writes the full word, req_be is ignored
//
// Handshake: a request is taken on a rising edge where req_valid=1 and
// req_ready=1 (req_ready is high only in IDLE). A response is presented with
// rsp_valid=1 and held unchanged until a rising edge where rsp_ready=1.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        req_ready,
   input  logic        rsp_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        stall,
   output logic [1:0]  dbg_state
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        hold_we;
   logic [31:0] hold_addr;
   logic [31:0] hold_wdata;

   logic [31:0] mem [DEPTH_WORDS];

   // Access-side view: with no wait states the access happens on the same
   // edge that accepts the request, so the live inputs are used directly.
   logic        acc_we;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [3:0]  wmask;
   logic        acc_err;
   logic [AW-1:0] acc_idx;
   logic        enter_resp;
   logic        mem_we;

   assign acc_we    = (state == IDLE) ? req_we    : hold_we;
   assign acc_addr  = (state == IDLE) ? req_addr  : hold_addr;
   assign acc_wdata = (state == IDLE) ? req_wdata : hold_wdata;

`ifdef DMEM_BYTE_EN
   logic [3:0] hold_be;
   assign wmask = (state == IDLE) ? req_be : hold_be;
`else
   logic unused_be;
   assign unused_be = ^req_be;
   assign wmask = 4'hF;
`endif

   assign acc_idx = acc_addr[AW+1:2];
   assign acc_err = (acc_addr[1:0] != 2'b00) || (|acc_addr[31:AW+2]);

   assign enter_resp = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (cnt == 4'd0));
   // Gated by reset so a request seen while reset is held never writes.
   assign mem_we = reset && enter_resp && acc_we && !acc_err;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign stall     = ((state == IDLE) && req_valid) || (state == WAIT) ||
                      ((state == RESP) && !rsp_ready);
   assign dbg_state = state;

   // Control FSM, request holding registers and registered response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         hold_we    <= 1'b0;
         hold_addr  <= 32'd0;
         hold_wdata <= 32'd0;
`ifdef DMEM_BYTE_EN
         hold_be    <= 4'd0;
`endif
         rsp_rdata  <= 32'd0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  hold_we    <= req_we;
                  hold_addr  <= req_addr;
                  hold_wdata <= req_wdata;
`ifdef DMEM_BYTE_EN
                  hold_be    <= req_be;
`endif
                  if (WAIT_CYCLES == 0) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= WAIT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) state <= RESP;
               else             cnt   <= cnt - 4'd1;
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (enter_resp) begin
            rsp_err <= acc_err;
            if (acc_err || acc_we) rsp_rdata <= 32'd0;
            else                   rsp_rdata <= mem[acc_idx];
         end
      end
   end

   // Storage write port; contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
         end
      end
   end

endmodule
